// File: rtl/cco_enc_pkg.sv
// cco_enc_pkg: shared helpers and derived constants for the CCO phase encoder.
package cco_enc_pkg;
    localparam int MAXN = 256;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int fmax(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int wrap_of(input int n, input int cw);
        return 2 * n * (1 << cw);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b = g;
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int popcount(input logic [MAXN-1:0] v);
        int c = 0;
        for (int i = 0; i < MAXN; i++) c += int'(v[i]);
        return c;
    endfunction

    // Odd ring phases arrive inverted; this mask undoes that.
    function automatic logic [MAXN-1:0] odd_mask();
        logic [MAXN-1:0] m = '0;
        for (int i = 1; i < MAXN; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [MAXN-1:0] ODD_MASK = odd_mask();
endpackage

// File: rtl/cco_fine_decode.sv
// cco_fine_decode: unscrambles sampled ring phases into a fine count and flags bubbles.
module cco_fine_decode
    import cco_enc_pkg::*;
#(
    parameter int NPHASES = 33,
    parameter int FW = 7
) (
    input  logic [NPHASES-1:0] fine_in,
    output logic [FW-1:0]      fine,
    output logic               bubble
);
    logic [NPHASES-1:0] u;
    int ones, trans;

    assign u = fine_in ^ ODD_MASK[NPHASES-1:0];

    always_comb begin
        ones = popcount(MAXN'(u));
        trans = 0;
        for (int i = 0; i < NPHASES - 1; i++) trans += int'(u[i] != u[i+1]);
    end

    // u[0] tells whether the edge is rising or falling through the ring.
    assign fine   = u[0] ? FW'(ones) : FW'(fmax(NPHASES) - ones);
    assign bubble = trans > 1;
endmodule

// File: rtl/cco_phase_encoder_gen2.sv
// cco_phase_encoder_gen2: fine/coarse ring-oscillator phases to an unwrapped or
// first-differenced binary count, four falling-edge pipeline stages.
module cco_phase_encoder_gen2
    import cco_enc_pkg::*;
#(
    parameter int NPHASES = 33,
    parameter int CW = 6,
    parameter int OW = 12,
    parameter int SEL_A = 0,
    parameter int SEL_B = 6
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               en,
    input  logic               mode,
    input  logic [CW-1:0]      count_coarse,
    input  logic [CW-1:0]      count_coarse_del,
    input  logic [NPHASES-1:0] count_fine,
    output logic [OW-1:0]      count_enc,
    output logic               count_valid,
    output logic               bubble_err
);
    localparam int WRAP = wrap_of(NPHASES, CW);
    localparam int EW = clog2(WRAP);
    localparam int FW = clog2(2 * NPHASES);
    localparam logic [EW-1:0] STEP = EW'(2 * NPHASES);
    localparam logic [EW-1:0] WRAP_EW = EW'(WRAP);
    localparam logic [OW-1:0] WRAP_OW = OW'(WRAP);

    logic [1:0] rsync;
    logic       rst_n;

    always_ff @(negedge clk or negedge resetb)
        if (!resetb) rsync <= '0;
        else rsync <= {rsync[0], 1'b1};

    assign rst_n = rsync[1];

    logic [NPHASES-1:0] f1;
    logic [CW-1:0]      cc1, cd1, coarse2, coarse_sel;
    logic [FW-1:0]      fine2, fine_dec;
    logic [EW-1:0]      enc3, prev, diff;
    logic [OW-1:0]      wrap_acc, wrap_new, sum;
    logic en1, md1, en2, md2, bub2, en3, md3, bub3, bub_dec, prime, ge;

    cco_fine_decode #(.NPHASES(NPHASES), .FW(FW)) u_fine (
        .fine_in(f1),
        .fine   (fine_dec),
        .bubble (bub_dec)
    );

    // Coarse sampled on the rising edge is only trusted well away from the fine transition.
    assign coarse_sel = (!f1[SEL_A] && !f1[SEL_B]) ? cc1 : cd1;

    always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) begin
            f1 <= ODD_MASK[NPHASES-1:0];
            {cc1, cd1, en1, md1} <= '0;
            {coarse2, fine2, bub2, en2, md2} <= '0;
            {enc3, bub3, en3, md3} <= '0;
        end else begin
            {f1, cc1, cd1, en1, md1} <= {count_fine, count_coarse, count_coarse_del, en, mode};
            coarse2 <= CW'(gray2bin(32'(coarse_sel)));
            {fine2, bub2, en2, md2} <= {fine_dec, bub_dec, en1, md1};
            enc3 <= STEP * EW'(coarse2) + EW'(fine2);
            {bub3, en3, md3} <= {bub2, en2, md2};
        end

    assign ge       = enc3 >= prev;
    assign wrap_new = ge ? wrap_acc : wrap_acc + WRAP_OW;
    assign sum      = OW'(enc3) + wrap_new;
    assign diff     = enc3 - prev + (ge ? '0 : WRAP_EW);

    always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) begin
            {count_enc, count_valid, bubble_err} <= '0;
            {prev, wrap_acc, prime} <= '0;
        end else begin
            count_valid <= en3 && (prime || !md3);
            bubble_err  <= en3 && (prime || !md3) && bub3;
            prime       <= en3;
            if (en3) begin
                prev     <= enc3;
                wrap_acc <= !prime ? '0 : (md3 ? wrap_acc : wrap_new);
                if (!prime) begin
                    if (!md3) count_enc <= OW'(enc3);
                end else
                    count_enc <= md3 ? OW'(diff) : sum;
            end
        end
endmodule

// File: tb/tb_cco_phase_encoder_gen2.sv
// tb_cco_phase_encoder_gen2: directed and random stimulus with a 4-deep expected-output queue.
module tb_cco_phase_encoder_gen2;
    localparam int N = 33;
    localparam int WRAP = 2 * N * 64;

    logic        clk = 0, resetb = 0, en = 0, mode = 0;
    logic [5:0]  count_coarse = '0, count_coarse_del = '0;
    logic [N-1:0] count_fine = '0;
    logic [11:0] count_enc;
    logic        count_valid, bubble_err;

    typedef struct {
        logic valid;
        int   enc;
        logic bub;
    } exp_t;

    exp_t q[$];
    int errors = 0, checks = 0;
    int m_prev = 0, m_wrap = 0, m_out = 0;
    logic m_prime = 0;

    cco_phase_encoder_gen2 dut (
        .clk(clk), .resetb(resetb), .en(en), .mode(mode),
        .count_coarse(count_coarse), .count_coarse_del(count_coarse_del),
        .count_fine(count_fine), .count_enc(count_enc),
        .count_valid(count_valid), .bubble_err(bubble_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input int exp);
        checks++;
        assert (act === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] to_raw(input logic [N-1:0] u);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = u[i] ^ i[0];
        return r;
    endfunction

    function automatic logic [N-1:0] therm(input int f);
        logic [N-1:0] u = '0;
        for (int i = 0; i < N; i++) u[i] = (f <= N) ? (i < f) : (i >= N - (2 * N - 1 - f));
        return u;
    endfunction

    function automatic logic [5:0] gray(input int c);
        logic [5:0] b = 6'(c);
        return b ^ (b >> 1);
    endfunction

    task automatic step(input logic e, input logic m, input logic [N-1:0] raw,
                        input logic [5:0] cc, input logic [5:0] cd, input int enc, input logic bub);
        exp_t x;
        @(posedge clk);
        if (q.size() == 4) begin
            x = q.pop_front();
            chk("valid", 32'(count_valid), int'(x.valid));
            chk("enc", 32'(count_enc), x.enc);
            chk("bubble", 32'(bubble_err), int'(x.bub));
        end
        en = e; mode = m; count_fine = raw; count_coarse = cc; count_coarse_del = cd;
        if (!e) begin
            x.valid = 0;
            m_prime = 0;
        end else if (!m_prime) begin
            m_prev = enc; m_wrap = 0; m_prime = 1;
            x.valid = !m;
            if (!m) m_out = enc % 4096;
        end else begin
            if (!m) begin
                if (enc < m_prev) m_wrap = (m_wrap + WRAP) % 4096;
                m_out = (enc + m_wrap) % 4096;
            end else
                m_out = ((enc - m_prev + WRAP) % WRAP) % 4096;
            m_prev = enc;
            x.valid = 1;
        end
        x.enc = m_out;
        x.bub = x.valid & bub;
        q.push_back(x);
    endtask

    task automatic samp(input logic e, input logic m, input int c, input int f);
        step(e, m, to_raw(therm(f)), gray(c), gray(c), 2 * N * c + f, 0);
    endtask

    task automatic idle();
        step(0, 0, to_raw('0), '0, '0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        resetb = 0; en = 0;
        #1;
        chk("rst_valid", 32'(count_valid), 0);
        chk("rst_enc", 32'(count_enc), 0);
        chk("rst_bubble", 32'(bubble_err), 0);
        q.delete();
        m_prev = 0; m_wrap = 0; m_out = 0; m_prime = 0;
        repeat (2) @(posedge clk);
        #1 chk("rst_hold_enc", 32'(count_enc), 0);
        @(posedge clk);
        resetb = 1;
        idle();
        idle();
    endtask

    initial begin
        count_fine = to_raw('0);
        do_reset();
        // decode: coarse_del chosen (137), then count_coarse chosen (60, wraps)
        step(1, 0, to_raw(33'h1F), 6'd0, 6'd3, 137, 0);
        step(1, 0, to_raw(33'h1F << 28), 6'd0, 6'd3, 60, 0);
        repeat (3) idle();
        samp(1, 0, 63, 42);
        samp(1, 0, 0, 20);
        samp(1, 0, 1, 34);
        idle();
        samp(1, 1, 63, 42);
        samp(1, 1, 0, 20);
        samp(1, 1, 1, 34);
        samp(1, 1, 1, 34);
        step(1, 0, to_raw(33'b1011), 6'd0, 6'd0, 3, 1);
        samp(1, 0, 0, 10);
        samp(1, 1, 0, 30);
        samp(1, 1, 2, 5);
        samp(1, 0, 5, 7);
        samp(1, 0, 6, 8);
        do_reset();
        samp(1, 1, 3, 3);
        samp(1, 1, 4, 4);
        samp(1, 0, 2, 65);
        samp(1, 0, 2, 65);
        for (int k = 0; k < 40; k++)
            samp($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 63)), int'($urandom_range(1, 65)));
        repeat (5) idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
